// File: rtl/mux_ctrl_pkg.sv
// Shared types and default parameters for the mux select controller.
// Pure definitions; no logic, no latency, no flow control.
package mux_ctrl_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int AUTO_PERIOD_DEF     = 1000;

endpackage

// File: rtl/mux_select_ctrl_if.sv
// Button/auto inputs and select outputs of the mux select controller.
// Plain level signals; no handshake, no backpressure.
interface mux_select_ctrl_if;
  logic btn_raw;
  logic auto_en;
  logic select;
  logic select_changed;
  logic btn_level;

  modport master (
    output btn_raw,
    output auto_en,
    input  select,
    input  select_changed,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    input  auto_en,
    output select,
    output select_changed,
    output btn_level
  );
endinterface

// File: rtl/mux_select_ctrl_debounce.sv
// Two-flop synchronizer plus debounce FSM; level changes after CYCLES stable samples.
// rise is combinational and coincides with the edge where level goes high; never stalls.
module debounce
  import mux_ctrl_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          s1;
  logic          s2;
  db_state_t     state;
  db_state_t     state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE_LOW;
      count <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    rise      = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          count_nxt = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = STABLE_LOW;
          count_nxt = '0;
        end else if (count == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          count_nxt = '0;
          rise      = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          count_nxt = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = STABLE_HIGH;
          count_nxt = '0;
        end else if (count == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        count_nxt = '0;
      end
    endcase
  end

  // WAIT_LOW still counts as high: the level only drops once the release is accepted.
  assign level = (state == STABLE_HIGH) || (state == WAIT_LOW);

endmodule

// File: rtl/mux_select_ctrl.sv
// Toggles the registered mux select on each debounced press or periodic auto event.
// Press reaches select DEBOUNCE_CYCLES+1 edges after btn_raw is first sampled high; no backpressure.
module mux_select_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mux_select_ctrl_if.slave   bus
);

  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic          press;
  logic          level;
  logic          auto_run;
  logic          auto_evt;
  logic          toggle;
  logic          select_q;
  logic          changed_q;
  logic [AW-1:0] auto_cnt;

  debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_raw),
    .level (level),
    .rise  (press)
  );

  // auto_run delays counting by one edge so the first toggle lands AUTO_PERIOD
  // edges after auto_en is first seen, matching the steady-state period.
  assign auto_evt = bus.auto_en && auto_run && (auto_cnt == AUTO_LAST);
  assign toggle   = press || auto_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_run  <= 1'b0;
      auto_cnt  <= '0;
      select_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      auto_run  <= bus.auto_en;
      changed_q <= toggle;
      if (toggle) begin
        select_q <= ~select_q;
      end
      if (toggle || !bus.auto_en) begin
        auto_cnt <= '0;
      end else if (auto_run) begin
        auto_cnt <= auto_cnt + 1'b1;
      end
    end
  end

  assign bus.select         = select_q;
  assign bus.select_changed = changed_q;
  assign bus.btn_level      = level;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Directed bench for mux_select_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
// Expected toggles (edge number, new select) are queued; a negedge monitor pops them.
module tb_mux_select_ctrl;

  typedef struct {
    int   edge_no;
    logic sel;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;
  exp_t exp_q[$];

  mux_select_ctrl_if bus();

  mux_select_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bus.select_changed !== 1'b0) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_toggle: edge=%0d select=%b changed=%b, none expected",
                 edge_n, bus.select, bus.select_changed);
      end else begin
        e = exp_q.pop_front();
        if (e.edge_no != edge_n || bus.select !== e.sel) begin
          bad = bad + 1;
          $display("FAIL toggle: got edge=%0d select=%b, want edge=%0d select=%b",
                   edge_n, bus.select, e.edge_no, e.sel);
        end
      end
    end
  end

  task automatic go(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s @edge %0d: got %b want %b", name, edge_n, act, exp);
    end
  endtask

  task automatic expect_toggle(input int e, input logic s);
    exp_t x;
    x.edge_no = e;
    x.sel     = s;
    exp_q.push_back(x);
  endtask

  logic [6:0] bounce_pat;

  initial begin
    reset       = 1'b1;
    bus.btn_raw = 1'b1;
    bus.auto_en = 1'b0;
    bounce_pat  = 7'b0111011;  // bit i drives the value sampled at edge 50+i

    // Reset held two edges with the button pressed
    for (int n = 1; n <= 2; n++) begin
      go(n);
      chk("rst_select", bus.select, 1'b0);
      chk("rst_changed", bus.select_changed, 1'b0);
      chk("rst_level", bus.btn_level, 1'b0);
    end
    bus.btn_raw = 1'b0;
    reset       = 1'b0;

    // Clean press sampled at 10 -> toggle at 15; second press -> back to 0
    go(9);  bus.btn_raw = 1'b1; expect_toggle(15, 1'b1);
    go(14); chk("press_level_pre", bus.btn_level, 1'b0);
            chk("press_select_pre", bus.select, 1'b0);
    go(15); chk("press_level", bus.btn_level, 1'b1);
    go(19); bus.btn_raw = 1'b0;
    go(25); chk("release_level", bus.btn_level, 1'b0);
            chk("release_select", bus.select, 1'b1);
    go(29); bus.btn_raw = 1'b1; expect_toggle(35, 1'b0);
    go(39); bus.btn_raw = 1'b0;

    // Bounce with runs of at most 3, then a hold from edge 57
    for (int i = 0; i < 7; i++) begin
      go(49 + i);
      chk("bounce_level", bus.btn_level, 1'b0);
      bus.btn_raw = bounce_pat[i];
    end
    go(56); bus.btn_raw = 1'b1; expect_toggle(62, 1'b1);
    go(61); chk("hold_level_pre", bus.btn_level, 1'b0);
            chk("hold_select_pre", bus.select, 1'b0);
    go(62); chk("hold_level", bus.btn_level, 1'b1);
    go(69); bus.btn_raw = 1'b0;

    // Auto mode from edge 80 to 105
    go(79);  bus.auto_en = 1'b1;
             expect_toggle(88, 1'b0);
             expect_toggle(96, 1'b1);
             expect_toggle(104, 1'b0);
    go(105); bus.auto_en = 1'b0;
    go(115); chk("auto_off_select", bus.select, 1'b0);

    // Press lands on the 136 wrap; later mid-phase press at 151 restarts the phase
    go(119); bus.auto_en = 1'b1;
             expect_toggle(128, 1'b1);
             expect_toggle(136, 1'b0);
             expect_toggle(144, 1'b1);
    go(130); bus.btn_raw = 1'b1;
    go(139); bus.btn_raw = 1'b0;
    go(145); bus.btn_raw = 1'b1;
             expect_toggle(151, 1'b0);
             expect_toggle(159, 1'b1);
             expect_toggle(167, 1'b0);
    go(159); bus.btn_raw = 1'b0;
    go(169); bus.auto_en = 1'b0;

    // Reset pulse mid-debounce with the button held
    go(179); bus.btn_raw = 1'b1;
    go(182); reset = 1'b1;
    go(183); chk("mid_rst_select", bus.select, 1'b0);
             chk("mid_rst_changed", bus.select_changed, 1'b0);
             chk("mid_rst_level", bus.btn_level, 1'b0);
             reset = 1'b0;
             expect_toggle(189, 1'b1);
    go(188); chk("mid_rst_level_pre", bus.btn_level, 1'b0);
             chk("mid_rst_select_pre", bus.select, 1'b0);
    go(189); chk("mid_rst_level_post", bus.btn_level, 1'b1);

    go(200);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL missing_toggles: %0d expected toggles never seen, next at edge %0d",
               exp_q.size(), exp_q[0].edge_no);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
